// File: rtl/ampel_taktgeber_pkg.sv
// Shared widths, limits and debounce state encoding for the traffic-light clock stage.
package ampel_taktgeber_pkg;

  localparam int ZAEHLER_BREITE = 3;
  localparam logic [ZAEHLER_BREITE-1:0] ZAEHLER_MAX = 3'd7;

  typedef enum logic [1:0] {
    LOS         = 2'd0,
    PRUEF_DRUCK = 2'd1,
    GEDRUECKT   = 2'd2,
    PRUEF_LOS   = 2'd3
  } entprell_zustand_t;

  // $clog2 returns 0 for an argument of 1; registers need at least one bit.
  function automatic int breite_min1(input int wert);
    return (wert < 1) ? 1 : wert;
  endfunction

endpackage

// File: rtl/ampel_taktgeber_entpreller.sv
// Button conditioning: two-flop synchroniser, debounce FSM and one-cycle press pulse.
module knopf_entpreller
  import ampel_taktgeber_pkg::*;
#(
  parameter int ENTPRELL_TAKTE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic knopf_roh,
  output logic knopf
);

  localparam int ZW = breite_min1($clog2(ENTPRELL_TAKTE + 1));
  localparam logic [ZW-1:0] ZIEL = ZW'(ENTPRELL_TAKTE - 1);
  localparam logic [ZW-1:0] EINS = ZW'(1);
  localparam logic SOFORT = (ENTPRELL_TAKTE == 1);

  logic              sync1_q, sync2_q;
  entprell_zustand_t zustand_q, zustand_d;
  logic [ZW-1:0]     zaehl_q, zaehl_d;
  logic              knopf_q, knopf_d;

  // Handshake: none; knopf is a plain one-cycle strobe with no back-pressure.
  always_comb begin
    zustand_d = zustand_q;
    zaehl_d   = zaehl_q;
    knopf_d   = 1'b0;
    case (zustand_q)
      LOS: begin
        if (sync2_q) begin
          if (SOFORT) begin
            zustand_d = GEDRUECKT;
            zaehl_d   = '0;
            knopf_d   = 1'b1;
          end else begin
            zustand_d = PRUEF_DRUCK;
            zaehl_d   = EINS;
          end
        end
      end
      PRUEF_DRUCK: begin
        if (!sync2_q) begin
          zustand_d = LOS;
          zaehl_d   = '0;
        end else if (zaehl_q == ZIEL) begin
          zustand_d = GEDRUECKT;
          zaehl_d   = '0;
          knopf_d   = 1'b1;
        end else begin
          zaehl_d = zaehl_q + EINS;
        end
      end
      GEDRUECKT: begin
        if (!sync2_q) begin
          if (SOFORT) begin
            zustand_d = LOS;
            zaehl_d   = '0;
          end else begin
            zustand_d = PRUEF_LOS;
            zaehl_d   = EINS;
          end
        end
      end
      PRUEF_LOS: begin
        // Release is qualified the same way as a press but never pulses.
        if (sync2_q) begin
          zustand_d = GEDRUECKT;
          zaehl_d   = '0;
        end else if (zaehl_q == ZIEL) begin
          zustand_d = LOS;
          zaehl_d   = '0;
        end else begin
          zaehl_d = zaehl_q + EINS;
        end
      end
      default: begin
        zustand_d = LOS;
        zaehl_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      zustand_q <= LOS;
      zaehl_q   <= '0;
      knopf_q   <= 1'b0;
    end else begin
      sync1_q   <= knopf_roh;
      sync2_q   <= sync1_q;
      zustand_q <= zustand_d;
      zaehl_q   <= zaehl_d;
      knopf_q   <= knopf_d;
    end
  end

  assign knopf = knopf_q;

endmodule

// File: rtl/ampel_taktgeber.sv
// Prescaled, enable-gated phase counter with cycle-start flag and debounced button pulse.
module ampel_taktgeber
  import ampel_taktgeber_pkg::*;
#(
  parameter int TAKT_TEILER    = 1,
  parameter int ENTPRELL_TAKTE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      laeuft,
  input  logic                      knopf_roh,
  output logic [ZAEHLER_BREITE-1:0] counter,
  output logic                      knopf,
  output logic                      zyklus_start
);

  localparam int VW = breite_min1($clog2(TAKT_TEILER));
  localparam logic [VW-1:0] VOR_MAX = VW'(TAKT_TEILER - 1);
  localparam logic [VW-1:0] VOR_EINS = VW'(1);

  logic [VW-1:0]             vor_q, vor_d;
  logic [ZAEHLER_BREITE-1:0] zaehler_q, zaehler_d;
  logic                      zyklus_q, zyklus_d;

  always_comb begin
    vor_d     = vor_q;
    zaehler_d = zaehler_q;
    zyklus_d  = 1'b0;
    if (laeuft) begin
      if (vor_q == VOR_MAX) begin
        vor_d     = '0;
        zaehler_d = zaehler_q + 3'd1;
        // Flag the cycle in which the counter first reads 0 after a wrap.
        zyklus_d  = (zaehler_q == ZAEHLER_MAX);
      end else begin
        vor_d = vor_q + VOR_EINS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vor_q     <= '0;
      zaehler_q <= '0;
      zyklus_q  <= 1'b0;
    end else begin
      vor_q     <= vor_d;
      zaehler_q <= zaehler_d;
      zyklus_q  <= zyklus_d;
    end
  end

  assign counter      = zaehler_q;
  assign zyklus_start = zyklus_q;

  knopf_entpreller #(
    .ENTPRELL_TAKTE(ENTPRELL_TAKTE)
  ) u_entpreller (
    .clk      (clk),
    .rst      (rst),
    .knopf_roh(knopf_roh),
    .knopf    (knopf)
  );

endmodule

// File: doc/ampel_taktgeber.md
Name: ampel_taktgeber

Overview:
- Upstream stage of the traffic-light controller. It generates the 3-bit phase counter and the conditioned pedestrian-button pulse that the controller consumes as `counter` and `knopf`.
- Replaces the free-running bench counter with a prescaled, enable-gated phase counter.
- Turns the raw, bouncing, asynchronous button into a synchronised, debounced, single-cycle press pulse.
- Also flags the start of each light cycle for downstream logging and sequencing.

Parameters:
- TAKT_TEILER, 1: clk edges per counter step; legal 1..65535.
- ENTPRELL_TAKTE, 4: consecutive stable synchronised samples needed to accept a level change; legal 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- laeuft  input  1  run enable for the phase counter; high = count.
- knopf_roh  input  1  raw, asynchronous, bouncing button level; high = pressed.
- counter  output  3  phase counter to the controller; wraps 7->0.
- knopf  output  1  one-cycle press pulse to the controller.
- zyklus_start  output  1  one-cycle pulse in the first cycle counter == 0 after a wrap.

Behaviour:
- One clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: counter=0, knopf=0, zyklus_start=0, prescaler=0, sync flops=0, debounce state=LOS, debounce count=0. Reset overrides all other activity, including mid-debounce and mid-prescale.
- Prescaler width: ceil(log2(TAKT_TEILER)), minimum 1 bit.
- Phase counter, on each edge with laeuft=1:
  - if prescaler == TAKT_TEILER-1: prescaler <= 0 and counter <= counter+1 (mod 8);
  - else prescaler <= prescaler+1.
  - With TAKT_TEILER=1 the counter steps on every enabled edge.
- laeuft=0: counter and prescaler hold; no zyklus_start.
- zyklus_start: registered; high for exactly the one cycle following the edge on which counter goes 7->0. It is not asserted out of reset.
- Synchroniser: two flops, knopf_roh -> s1 -> s2. The debounce FSM sees only s2.
- Debounce FSM (state plus count; count width ceil(log2(ENTPRELL_TAKTE+1))):
  - LOS: if s2=1, go to GEDRUECKT with a pulse when N=1; otherwise go to PRUEF_DRUCK with count=1.
  - PRUEF_DRUCK: if s2=0, go to LOS with count=0. If s2=1 and count==N-1, go to GEDRUECKT and set knopf<=1. Otherwise count++.
  - GEDRUECKT: if s2=0, go to LOS when N=1; otherwise go to PRUEF_LOS with count=1.
  - PRUEF_LOS: if s2=1, go to GEDRUECKT with count=0. If s2=0 and count==N-1, go to LOS. Otherwise count++. Release never generates a pulse.
- knopf is high for exactly one cycle per accepted press; it is 0 in every other cycle.
- Press latency: let E0 be the first edge that samples knopf_roh=1. knopf is high in the cycle after edge E(N+1).
- Holding the button for any duration gives one pulse. A bounce shorter than N samples gives no pulse.
- Button path is independent of laeuft and of counter.
- If the button is held through reset, it is treated as a new press after reset deasserts: pulse after E(N+1) counted from the first post-reset edge.
- No simultaneous-event conflicts: counter path and button path share no state.

Decomposition:
- Shared package: ZAEHLER_BREITE=3, ZAEHLER_MAX=3'd7, debounce state encoding (LOS=2'd0, PRUEF_DRUCK=2'd1, GEDRUECKT=2'd2, PRUEF_LOS=2'd3).
- One sub-module, knopf_entpreller (ports clk, rst, knopf_roh, knopf; parameter ENTPRELL_TAKTE). It holds the synchroniser, FSM and pulse generation.
- Prescaler, counter and zyklus_start stay in the top module.

Test Plan:
1. Count and wrap: rst 2 cycles, laeuft=1, TAKT_TEILER=1 -> counter 0,1,…,7,0,1; zyklus_start high only in the cycle counter first reads 0 after 7, i.e. once per 8 cycles.
2. Prescale and hold: TAKT_TEILER=3 -> counter steps every 3rd edge. laeuft=0 for 5 edges mid-prescale (prescaler=1) -> counter and prescaler frozen. On resume, the next step comes 2 edges later.
3. Bounce then press: N=4, knopf_roh pattern 1,0,1,0,1,0 per cycle, then steady 1 for 12 cycles -> exactly one knopf pulse, in the cycle after edge E5 of the steady run. Release with the same bounce -> no pulse.
4. Glitch rejection: N=4, knopf_roh high for 3 cycles, then low -> knopf stays 0; FSM returns to LOS.
5. Long hold: knopf_roh high for 100 cycles -> exactly one pulse.
6. Reset mid-operation: rst asserted while in PRUEF_DRUCK (count=2) and counter=5, with knopf_roh held 1:
   - next cycle: counter=0, knopf=0, zyklus_start=0;
   - after rst drops: one pulse after E5 counted from the first post-reset edge.
